hilo_muldiv: RTL and testbench

- Owns the HI/LO architectural registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in EX beside the ALU and is the writer side of HI/LO.
- Decode's HI/LO-use flags (MFHI/MFLO readers) enter through `use_hilo`; the block returns a stall while a multi-cycle operation is in flight.
- Multiply and divide are iterative, radix-2, one bit per cycle.

---
 rtl/hilo_muldiv_if.sv | 27 ++
 rtl/hilo_muldiv.sv | 153 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between EX and the HI/LO multiply-divide unit.
// master: the pipeline side; slave: the hilo_muldiv unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             use_hilo;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel, use_hilo,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, use_hilo,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register owner. MTHI/MTLO write in one edge; MULT/MULTU/DIV/DIVU
// run iteratively (one bit per cycle) on magnitudes, then a FIX cycle
// applies sign correction and writes HI/LO.
// WIDTH must match the WIDTH of the connected hilo_muldiv_if.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  hilo_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd_b;
  logic [WIDTH-1:0]     raw_a;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 op_signed;
  logic                 op_div;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = bus.use_hilo && busy_q;

  // Issue decode: operand magnitudes and signs for the accepted op.
  always_comb begin
    op_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
    op_div    = (bus.op == 3'd2) || (bus.op == 3'd3);
    a_neg     = op_signed && bus.src_a[WIDTH-1];
    b_neg     = op_signed && bus.src_b[WIDTH-1];
    a_mag     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    b_mag     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for
  // divide (remainder in the upper half, quotient bits enter at bit 0).
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd_b};
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    q_fix    = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    r_fix    = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath registers and HI/LO with registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd_b <= '0;
      raw_a  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (bus.op)
              3'd4: hi_q <= bus.src_a;
              3'd5: lo_q <= bus.src_a;
              3'd0, 3'd1, 3'd2, 3'd3: begin
                acc    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                opnd_b <= op_div ? b_mag : a_mag;
                raw_a  <= bus.src_a;
                is_div <= op_div;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                div0   <= op_div && (bus.src_b == '0);
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.cancel) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= acc_next;
            if (cnt == LAST)
              state <= FIX;
            else
              cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            if (!is_div) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (div0) begin
              hi_q <= raw_a;
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
            done_q <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed + scoreboard bench for hilo_muldiv: expected HI/LO pairs are
// queued at issue time and popped when done pulses.
module tb_hilo_muldiv;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] expq[$];

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model built on native SV arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    int sq, sr;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // One-cycle issue pulse; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, then pops the scoreboard and checks timing.
  task automatic waitResult(input string tag, input int expBusy, input bit chkStall);
    int busyCycles = 0;
    int stallCycles = 0;
    bit seen = 1'b0;
    logic [63:0] exp;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyCycles++;
      if (bus.stall) stallCycles++;
      @(negedge clk);
    end
    checkOutput({tag, " done_seen"}, 64'(seen), 64'd1);
    exp = (expq.size() > 0) ? expq.pop_front() : 64'hx;
    checkOutput({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    checkOutput({tag, " busy_cycles"}, 64'(busyCycles), 64'(expBusy));
    checkOutput({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    if (chkStall) begin
      checkOutput({tag, " stall_cycles"}, 64'(stallCycles), 64'(expBusy));
      checkOutput({tag, " stall_after"}, 64'(bus.stall), 64'd0);
    end
    @(negedge clk);
    checkOutput({tag, " done_width"}, 64'(bus.done), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    expq.push_back(exp);
    applyStimulus(op, a, b);
    waitResult(tag, 33, 1'b0);
  endtask

  initial begin
    int doneCount;
    logic [31:0] ra, rb;
    logic [2:0] rop;

    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.cancel = 1'b0;
    bus.use_hilo = 1'b0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed arithmetic");
    runOp("MULT -3*7", 3'd0, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB});
    runOp("MULTU max*max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    runOp("DIVU 100/7", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    runOp("DIV -7/2", 3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    runOp("DIV min/-1", 3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    runOp("DIVU by 0", 3'd3, 32'h1234, 32'd0, {32'h00001234, 32'hFFFFFFFF});
    runOp("DIV -5 by 0", 3'd2, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF});

    $display("[TB] random arithmetic against model");
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd3;
      runOp($sformatf("rand op%0d %h,%h", rop, ra, rb), rop, ra, rb, model(rop, ra, rb));
    end

    $display("[TB] MTHI/MTLO back to back");
    bus.op = 3'd4; bus.src_a = 32'hA5A5A5A5; bus.start = 1'b1;
    @(negedge clk);
    checkOutput("MTHI hi", 64'(bus.hi), 64'hA5A5A5A5);
    checkOutput("MTHI busy", 64'(bus.busy), 64'd0);
    bus.op = 3'd5; bus.src_a = 32'h5A5A5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("MTLO hilo", {bus.hi, bus.lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    checkOutput("MTLO busy", 64'(bus.busy), 64'd0);

    $display("[TB] MULT with reader stalled");
    bus.use_hilo = 1'b1;
    expq.push_back({32'd0, 32'd12});
    applyStimulus(3'd0, 32'd3, 32'd4);
    waitResult("MULT 3*4 stall", 33, 1'b1);
    bus.use_hilo = 1'b0;

    $display("[TB] start while busy and reserved op");
    expq.push_back({32'd0, 32'd30});
    applyStimulus(3'd1, 32'd5, 32'd6);
    bus.op = 3'd4; bus.src_a = 32'hDEADBEEF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitResult("MULTU with stray start", 32, 1'b0);
    applyStimulus(3'd6, 32'h11111111, 32'd1);
    checkOutput("reserved op busy", 64'(bus.busy), 64'd0);
    checkOutput("reserved op hilo", {bus.hi, bus.lo}, {32'd0, 32'd30});

    $display("[TB] cancel with start in IDLE");
    bus.cancel = 1'b1;
    applyStimulus(3'd4, 32'h00000777, 32'd0);
    bus.cancel = 1'b0;
    checkOutput("cancel+MTHI hi", 64'(bus.hi), 64'd0);

    $display("[TB] cancel mid-run");
    applyStimulus(3'd4, 32'd1, 32'd0);
    applyStimulus(3'd5, 32'd2, 32'd0);
    applyStimulus(3'd2, 32'd10, 32'd3);
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checkOutput("cancel busy", 64'(bus.busy), 64'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) doneCount++;
      @(negedge clk);
    end
    checkOutput("cancel done count", 64'(doneCount), 64'd0);
    checkOutput("cancel hilo", {bus.hi, bus.lo}, {32'd1, 32'd2});

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(3'd2, 32'd10, 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("pre-reset busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 64'(bus.busy), 64'd0);
    checkOutput("async reset hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) doneCount++;
      @(negedge clk);
    end
    checkOutput("post-reset done count", 64'(doneCount), 64'd0);
    checkOutput("post-reset hilo", {bus.hi, bus.lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
